adder_share_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer that shares one 4-bit adder datapath (sum plus signed/unsigned

---
 rtl/adder_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_adder_share_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit adder between two requesters.
// Captures the winner's operands, holds them for ADD_LAT cycles, then latches sum/flags and pulses done.
module adder_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int ADD_LAT = 1
) (
    input  logic             clock_100MHz,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_ov_s,
    input  logic             add_ov_u,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_ov_s,
    output logic             res_ov_u,
    output logic             last_id,
    output logic             busy
);

    // ADD_LAT below 1 is not a legal configuration; the guard only keeps the width sane.
    localparam int CNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic               rr_ptr_reg, rr_ptr_next;
    logic               id_reg, id_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         gnt_reg, gnt_next;
    logic [1:0]         done_reg, done_next;
    logic [WIDTH-1:0]   add_a_reg, add_a_next;
    logic [WIDTH-1:0]   add_b_reg, add_b_next;
    logic [WIDTH-1:0]   res_sum_reg, res_sum_next;
    logic               res_ov_s_reg, res_ov_s_next;
    logic               res_ov_u_reg, res_ov_u_next;
    logic               last_id_reg, last_id_next;
    logic               busy_reg, busy_next;
    logic               winner;

    logic [1:0]         req_vec;
    logic [WIDTH-1:0]   a_vec [2];
    logic [WIDTH-1:0]   b_vec [2];

    assign req_vec  = {req1, req0};
    assign a_vec[0] = a0;
    assign a_vec[1] = a1;
    assign b_vec[0] = b0;
    assign b_vec[1] = b1;

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        id_next       = id_reg;
        cnt_next      = cnt_reg;
        gnt_next      = '0;
        done_next     = '0;
        add_a_next    = add_a_reg;
        add_b_next    = add_b_reg;
        res_sum_next  = res_sum_reg;
        res_ov_s_next = res_ov_s_reg;
        res_ov_u_next = res_ov_u_reg;
        last_id_next  = last_id_reg;
        winner        = rr_ptr_reg;

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    // A lone requester wins outright; rr_ptr only breaks ties.
                    winner           = (&req_vec) ? rr_ptr_reg : req_vec[1];
                    gnt_next[winner] = 1'b1;
                    add_a_next       = a_vec[winner];
                    add_b_next       = b_vec[winner];
                    cnt_next         = CNT_W'(ADD_LAT);
                    id_next          = winner;
                    state_next       = EXEC;
                end
            end
            EXEC: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    res_sum_next      = add_sum;
                    res_ov_s_next     = add_ov_s;
                    res_ov_u_next     = add_ov_u;
                    last_id_next      = id_reg;
                    done_next[id_reg] = 1'b1;
                    rr_ptr_next       = ~id_reg;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == EXEC);
    end

    always_ff @(posedge clock_100MHz or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 1'b0;
            id_reg       <= 1'b0;
            cnt_reg      <= '0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            res_sum_reg  <= '0;
            res_ov_s_reg <= 1'b0;
            res_ov_u_reg <= 1'b0;
            last_id_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            id_reg       <= id_next;
            cnt_reg      <= cnt_next;
            gnt_reg      <= gnt_next;
            done_reg     <= done_next;
            add_a_reg    <= add_a_next;
            add_b_reg    <= add_b_next;
            res_sum_reg  <= res_sum_next;
            res_ov_s_reg <= res_ov_s_next;
            res_ov_u_reg <= res_ov_u_next;
            last_id_reg  <= last_id_next;
            busy_reg     <= busy_next;
        end
    end

    assign gnt0     = gnt_reg[0];
    assign gnt1     = gnt_reg[1];
    assign done0    = done_reg[0];
    assign done1    = done_reg[1];
    assign add_a    = add_a_reg;
    assign add_b    = add_b_reg;
    assign res_sum  = res_sum_reg;
    assign res_ov_s = res_ov_s_reg;
    assign res_ov_u = res_ov_u_reg;
    assign last_id  = last_id_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: one instance with ADD_LAT=1, one with ADD_LAT=3,
// each wired to a behavioural adder; completions are checked against a scoreboard queue.
module tb_adder_share_arbiter;

    logic       clk;
    logic       reset;

    // ADD_LAT=1 instance
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0_1, gnt1_1, done0_1, done1_1;
    logic [3:0] add_a1, add_b1, sum1, res_sum1;
    logic       ov_s1, ov_u1, res_ov_s1, res_ov_u1, last_id1, busy1;

    // ADD_LAT=3 instance
    logic       req0_3, req1_3;
    logic [3:0] a0_3, b0_3, a1_3, b1_3;
    logic       gnt0_3, gnt1_3, done0_3, done1_3;
    logic [3:0] add_a3, add_b3, sum3, res_sum3;
    logic       ov_s3, ov_u3, res_ov_s3, res_ov_u3, last_id3, busy3;

    typedef struct packed {
        logic       id;
        logic [3:0] sum;
        logic       ovs;
        logic       ovu;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    adder_share_arbiter #(.WIDTH(4), .ADD_LAT(1)) u_dut1 (
        .clock_100MHz(clk), .reset(reset),
        .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0_1), .gnt1(gnt1_1), .done0(done0_1), .done1(done1_1),
        .add_a(add_a1), .add_b(add_b1),
        .add_sum(sum1), .add_ov_s(ov_s1), .add_ov_u(ov_u1),
        .res_sum(res_sum1), .res_ov_s(res_ov_s1), .res_ov_u(res_ov_u1),
        .last_id(last_id1), .busy(busy1)
    );

    adder_share_arbiter #(.WIDTH(4), .ADD_LAT(3)) u_dut3 (
        .clock_100MHz(clk), .reset(reset),
        .req0(req0_3), .req1(req1_3), .a0(a0_3), .b0(b0_3), .a1(a1_3), .b1(b1_3),
        .gnt0(gnt0_3), .gnt1(gnt1_3), .done0(done0_3), .done1(done1_3),
        .add_a(add_a3), .add_b(add_b3),
        .add_sum(sum3), .add_ov_s(ov_s3), .add_ov_u(ov_u3),
        .res_sum(res_sum3), .res_ov_s(res_ov_s3), .res_ov_u(res_ov_u3),
        .last_id(last_id3), .busy(busy3)
    );

    // Behavioural adder: {ov_s, ov_u, sum}; ADD_LAT cycles means ADD_LAT-1 register stages
    // so the result is settled when the arbiter samples it.
    function automatic logic [5:0] add_fn(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {(a[3] == b[3]) && (s[3] != a[3]), s[4], s[3:0]};
    endfunction

    assign {ov_s1, ov_u1, sum1} = add_fn(add_a1, add_b1);

    logic [5:0] pipe3 [0:1];
    always @(posedge clk) begin
        pipe3[0] <= add_fn(add_a3, add_b3);
        pipe3[1] <= pipe3[0];
    end
    assign {ov_s3, ov_u3, sum3} = pipe3[1];

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [3:0] sum, input logic ovs, input logic ovu);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        e.ovs = ovs;
        e.ovu = ovu;
        return e;
    endfunction

    task automatic check_done(input string tag, input logic d0, input logic d1, input logic lid,
                              input logic [3:0] s, input logic ovs, input logic ovu);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        $display("txn %s id=%0d sum=%0d ov_s=%0b ov_u=%0b (expect id=%0d sum=%0d ov_s=%0b ov_u=%0b)",
                 tag, lid, s, ovs, ovu, e.id, e.sum, e.ovs, e.ovu);
        chk({tag, "_done"}, 32'({d1, d0}), e.id ? 32'd2 : 32'd1);
        chk({tag, "_last_id"}, 32'(lid), 32'(e.id));
        chk({tag, "_res_sum"}, 32'(s), 32'(e.sum));
        chk({tag, "_ov_s"}, 32'(ovs), 32'(e.ovs));
        chk({tag, "_ov_u"}, 32'(ovu), 32'(e.ovu));
    endtask

    initial begin
        reset  = 1'b0;
        req0   = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        req0_3 = 0; req1_3 = 0; a0_3 = 0; b0_3 = 0; a1_3 = 0; b1_3 = 0;

        // Reset asserted mid-cycle, before any rising edge
        #2;
        chk("rst_dut1_outputs", 32'({gnt0_1, gnt1_1, done0_1, done1_1, add_a1, add_b1,
                                     res_sum1, res_ov_s1, res_ov_u1, last_id1, busy1}), 32'd0);
        chk("rst_dut3_outputs", 32'({gnt0_3, gnt1_3, done0_3, done1_3, add_a3, add_b3,
                                     res_sum3, res_ov_s3, res_ov_u3, last_id3, busy3}), 32'd0);
        #3;
        reset = 1'b1;
        tick();
        tick();
        chk("idle_no_gnt", 32'({gnt0_1, gnt1_1, gnt0_3, gnt1_3, busy1, busy3}), 32'd0);

        // Single request, ADD_LAT=1: 8+8 -> 0 with both overflows
        req0 = 1; a0 = 4'd8; b0 = 4'd8;
        sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1));
        tick();
        chk("t2_gnt", 32'({gnt1_1, gnt0_1}), 32'd1);
        chk("t2_add_ops", 32'({add_a1, add_b1}), 32'h88);
        chk("t2_busy", 32'(busy1), 32'd1);
        req0 = 0;
        tick();
        chk("t2_gnt_pulse", 32'({gnt1_1, gnt0_1}), 32'd0);
        chk("t2_busy_done", 32'(busy1), 32'd0);
        check_done("t2", done0_1, done1_1, last_id1, res_sum1, res_ov_s1, res_ov_u1);

        // Operand change after grant is ignored: 2+3 = 5
        req0 = 1; a0 = 4'd2; b0 = 4'd3;
        sb.push_back(mk(1'b0, 4'd5, 1'b0, 1'b0));
        tick();
        chk("t4_gnt", 32'({gnt1_1, gnt0_1}), 32'd1);
        a0 = 4'd15; req0 = 0;
        tick();
        chk("t4_add_a_held", 32'(add_a1), 32'd2);
        check_done("t4", done0_1, done1_1, last_id1, res_sum1, res_ov_s1, res_ov_u1);

        // Reset during EXEC aborts the op and clears results
        req1 = 1; a1 = 4'd5; b1 = 4'd6;
        tick();
        chk("t5_gnt1", 32'({gnt1_1, gnt0_1}), 32'd2);
        chk("t5_busy", 32'(busy1), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_outputs", 32'({gnt0_1, gnt1_1, done0_1, done1_1, add_a1, add_b1,
                                   res_sum1, res_ov_s1, res_ov_u1, last_id1, busy1}), 32'd0);
        tick();
        chk("t5_no_done", 32'({done1_1, done0_1}), 32'd0);
        reset = 1'b1;

        // Continuous dual requests alternate 0,1,0,1 starting with 0 after reset
        req0 = 1; req1 = 1; a0 = 4'd3; b0 = 4'd4; a1 = 4'd7; b1 = 4'd1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back(mk(1'b0, 4'd7, 1'b0, 1'b0));
            else            sb.push_back(mk(1'b1, 4'd8, 1'b1, 1'b0));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3_gnt_%0d", i), 32'({gnt1_1, gnt0_1}), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check_done($sformatf("t3_op%0d", i), done0_1, done1_1, last_id1,
                       res_sum1, res_ov_s1, res_ov_u1);
            if (i == 3) begin
                req0 = 0;
                req1 = 0;
            end
        end
        tick();
        chk("t3_quiet", 32'({gnt1_1, gnt0_1, busy1}), 32'd0);

        // ADD_LAT=3: 9+9 -> 2 with both overflows, operands held for 3 cycles
        req1_3 = 1; a1_3 = 4'd9; b1_3 = 4'd9;
        sb.push_back(mk(1'b1, 4'd2, 1'b1, 1'b1));
        tick();
        chk("t6_gnt1", 32'({gnt1_3, gnt0_3}), 32'd2);
        chk("t6_ops_c0", 32'({add_a3, add_b3}), 32'h99);
        req1_3 = 0; a1_3 = 4'd0; b1_3 = 4'd0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk($sformatf("t6_no_done_c%0d", k), 32'({done1_3, done0_3}), 32'd0);
            chk($sformatf("t6_ops_c%0d", k), 32'({add_a3, add_b3}), 32'h99);
            chk($sformatf("t6_busy_c%0d", k), 32'(busy3), 32'd1);
        end
        tick();
        chk("t6_ops_c3", 32'({add_a3, add_b3}), 32'h99);
        check_done("t6", done0_3, done1_3, last_id3, res_sum3, res_ov_s3, res_ov_u3);
        tick();
        chk("t6_done_pulse", 32'({done1_3, done0_3, busy3}), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
